// File: rtl/ram_stream_loader.sv
`default_nettype none
// ============================================================================
// Module      : ram_stream_loader
// Description : Packs a valid/ready byte stream into 16-bit words, writes them
//               to consecutive RAM addresses and sums them into a checksum.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_stream_loader #(
    parameter int ADDR_W          = 16,
    parameter bit BYTE_FIRST_HIGH = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] count,
    input  logic [7:0]        byte_data,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic [ADDR_W-1:0] ram_address,
    output logic [15:0]       ram_in,
    output logic              ram_load,
    output logic              busy,
    output logic              done,
    output logic [15:0]       checksum
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_HI    = 3'd1;
    localparam logic [2:0] c_LO    = 3'd2;
    localparam logic [2:0] c_WRITE = 3'd3;
    localparam logic [2:0] c_FIN   = 3'd4;

    localparam logic [ADDR_W-1:0] c_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] c_ZERO = '0;

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_count;
    logic [ADDR_W-1:0] r_index;
    logic [7:0]        r_hold;
    logic              r_byte_ready;
    logic [ADDR_W-1:0] r_ram_address;
    logic [15:0]       r_ram_in;
    logic              r_ram_load;
    logic              r_busy;
    logic              r_done;
    logic [15:0]       r_checksum;

    logic              w_xfer;
    logic [15:0]       w_word;
    logic [ADDR_W-1:0] w_index_next;

    assign w_xfer       = byte_valid & r_byte_ready;
    assign w_index_next = r_index + c_ONE;

    generate
        if (BYTE_FIRST_HIGH) begin : g_hi_first
            assign w_word = {r_hold, byte_data};
        end else begin : g_lo_first
            assign w_word = {byte_data, r_hold};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_IDLE;
            r_base        <= '0;
            r_count       <= '0;
            r_index       <= '0;
            r_hold        <= '0;
            r_byte_ready  <= 1'b0;
            r_ram_address <= '0;
            r_ram_in      <= '0;
            r_ram_load    <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_checksum    <= '0;
        end else begin
            r_ram_load <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_base     <= base;
                        r_count    <= count;
                        r_index    <= '0;
                        r_checksum <= '0;
                        r_busy     <= 1'b1;
                        if (count == c_ZERO) begin
                            r_state <= c_FIN;
                            r_done  <= 1'b1;
                        end else begin
                            r_state      <= c_HI;
                            r_byte_ready <= 1'b1;
                        end
                    end
                end
                c_HI: begin
                    if (w_xfer) begin
                        r_hold  <= byte_data;
                        r_state <= c_LO;
                    end
                end
                c_LO: begin
                    // Address and data are registered here so they are stable
                    // for the entire write cycle that follows.
                    if (w_xfer) begin
                        r_ram_in      <= w_word;
                        r_ram_address <= r_base + r_index;
                        r_ram_load    <= 1'b1;
                        r_byte_ready  <= 1'b0;
                        r_state       <= c_WRITE;
                    end
                end
                c_WRITE: begin
                    r_checksum <= r_checksum + r_ram_in;
                    r_index    <= w_index_next;
                    if (w_index_next == r_count) begin
                        r_state <= c_FIN;
                        r_done  <= 1'b1;
                    end else begin
                        r_state      <= c_HI;
                        r_byte_ready <= 1'b1;
                    end
                end
                c_FIN: begin
                    r_state <= c_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state      <= c_IDLE;
                    r_busy       <= 1'b0;
                    r_byte_ready <= 1'b0;
                end
            endcase
        end
    end

    assign byte_ready  = r_byte_ready;
    assign ram_address = r_ram_address;
    assign ram_in      = r_ram_in;
    assign ram_load    = r_ram_load;
    assign busy        = r_busy;
    assign done        = r_done;
    assign checksum    = r_checksum;

endmodule
`default_nettype wire
